// File: rtl/whisky_writeback.sv
// Writeback stage for the whisky register file: merges ALU results with in-order
// load responses into one registered write per cycle and exports a busy scoreboard.
module whisky_writeback #(
    parameter int DATA_W   = 16,
    parameter int SEL_W    = 3,
    parameter int LQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [SEL_W-1:0]      i_alu_dest,
    input  logic [DATA_W-1:0]     i_alu_data,
    input  logic                  i_ld_issue,
    input  logic [SEL_W-1:0]      i_ld_dest,
    output logic                  o_ld_ready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_rf_we,
    output logic [SEL_W-1:0]      o_rf_sel_w,
    output logic [DATA_W-1:0]     o_rf_data,
    output logic [2**SEL_W-1:0]   o_busy,
    output logic [SEL_W-1:0]      o_lq_count,
    output logic                  o_err_unexp
);

    localparam int NREG  = 2**SEL_W;
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = $clog2(LQ_DEPTH + 1);

    typedef struct packed {
        logic [SEL_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic [SEL_W-1:0] r_lq_dest [LQ_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_skid_vld;
    wb_t              r_skid;
    logic             r_we;
    wb_t              r_wb;
    logic             r_err;

    logic             w_alu_ready;
    logic             w_alu_fire;
    logic             w_lq_empty;
    logic             w_ld_ready;
    logic             w_pop;
    logic             w_push;
    logic             w_src_vld;
    wb_t              w_src;
    wb_t              w_alu;
    logic             w_skid_load;
    logic             w_skid_clr;
    logic             w_wr;
    logic [PTR_W-1:0] w_off     [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] w_ent_vld;
    logic [NREG-1:0]  w_busy;

    // alu_ready depends only on registered state so decode never sees a path from memory
    assign w_alu_ready = !r_skid_vld;
    assign w_alu_fire  = i_alu_valid && w_alu_ready;
    assign w_lq_empty  = (r_count == '0);
    assign w_ld_ready  = (r_count != CNT_W'(LQ_DEPTH));
    assign w_pop       = i_mem_rvalid && !w_lq_empty;
    assign w_push      = i_ld_issue && w_ld_ready;
    assign w_alu.dest  = i_alu_dest;
    assign w_alu.data  = i_alu_data;

    always_comb begin
        w_src_vld   = 1'b0;
        w_src       = '0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        if (w_pop) begin
            w_src_vld   = 1'b1;
            w_src.dest  = r_lq_dest[r_head];
            w_src.data  = i_mem_rdata;
            w_skid_load = w_alu_fire;
        end else if (r_skid_vld) begin
            w_src_vld  = 1'b1;
            w_src      = r_skid;
            w_skid_clr = 1'b1;
        end else if (w_alu_fire) begin
            w_src_vld = 1'b1;
            w_src     = w_alu;
        end
    end

    // r0 is hardwired: its source is consumed but nothing is written
    assign w_wr = w_src_vld && (w_src.dest != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) r_lq_dest[i] <= '0;
        end else begin
            if (w_push) begin
                r_lq_dest[r_tail] <= i_ld_dest;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_vld <= 1'b0;
            r_skid     <= '0;
        end else if (w_skid_load) begin
            r_skid_vld <= 1'b1;
            r_skid     <= w_alu;
        end else if (w_skid_clr) begin
            r_skid_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_wb  <= '0;
            r_err <= 1'b0;
        end else begin
            r_we <= w_wr;
            if (w_wr) r_wb <= w_src;
            if (i_mem_rvalid && w_lq_empty) r_err <= 1'b1;
        end
    end

    // an entry is live when its distance from head is below the occupancy
    for (genvar g = 0; g < LQ_DEPTH; g++) begin : g_ent
        assign w_off[g]     = PTR_W'(g) - r_head;
        assign w_ent_vld[g] = (CNT_W'(w_off[g]) < r_count);
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (w_ent_vld[i]) w_busy[r_lq_dest[i]] = 1'b1;
        end
        if (r_skid_vld) w_busy[r_skid.dest] = 1'b1;
        if (r_we)       w_busy[r_wb.dest]   = 1'b1;
        w_busy[0] = 1'b0;
    end

    assign o_alu_ready = w_alu_ready;
    assign o_ld_ready  = w_ld_ready;
    assign o_rf_we     = r_we;
    assign o_rf_sel_w  = r_wb.dest;
    assign o_rf_data   = r_wb.data;
    assign o_busy      = w_busy;
    assign o_lq_count  = SEL_W'(r_count);
    assign o_err_unexp = r_err;

endmodule

// File: tb/tb_whisky_writeback.sv
// Directed bench for whisky_writeback: queue-based reference model checked every
// cycle, plus hand-computed expectations after each directed step.
module tb_whisky_writeback;

    localparam int DATA_W   = 16;
    localparam int SEL_W    = 3;
    localparam int LQ_DEPTH = 4;
    localparam int NREG     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [SEL_W-1:0]  alu_dest = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              ld_issue = 1'b0;
    logic [SEL_W-1:0]  ld_dest = '0;
    logic              ld_ready;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              rf_we;
    logic [SEL_W-1:0]  rf_sel_w;
    logic [DATA_W-1:0] rf_data;
    logic [NREG-1:0]   busy;
    logic [SEL_W-1:0]  lq_count;
    logic              err_unexp;

    always #5 clk = ~clk;

    whisky_writeback #(.DATA_W(DATA_W), .SEL_W(SEL_W), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready),
        .i_alu_dest(alu_dest), .i_alu_data(alu_data),
        .i_ld_issue(ld_issue), .i_ld_dest(ld_dest), .o_ld_ready(ld_ready),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_rf_we(rf_we), .o_rf_sel_w(rf_sel_w), .o_rf_data(rf_data),
        .o_busy(busy), .o_lq_count(lq_count), .o_err_unexp(err_unexp)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // reference model: pending loads as a queue, one optional held ALU result
    logic [SEL_W-1:0]  m_q[$];
    bit                m_skid_v;
    logic [SEL_W-1:0]  m_skid_d;
    logic [DATA_W-1:0] m_skid_x;
    bit                m_we;
    logic [SEL_W-1:0]  m_sel;
    logic [DATA_W-1:0] m_data;
    bit                m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] b = '0;
        foreach (m_q[i]) b[m_q[i]] = 1'b1;
        if (m_skid_v) b[m_skid_d] = 1'b1;
        if (m_we) b[m_sel] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_skid_v = 0; m_skid_d = '0; m_skid_x = '0;
        m_we = 0; m_sel = '0; m_data = '0; m_err = 0;
    endtask

    task automatic model_step();
        bit fire, resp, push, got;
        logic [SEL_W-1:0]  d;
        logic [DATA_W-1:0] x;
        fire = alu_valid && !m_skid_v;
        resp = mem_rvalid && (m_q.size() > 0);
        push = ld_issue && (m_q.size() < LQ_DEPTH);
        if (mem_rvalid && m_q.size() == 0) m_err = 1;
        got = 0; d = '0; x = '0;
        if (resp) begin
            got = 1; d = m_q.pop_front(); x = mem_rdata;
            if (fire) begin m_skid_v = 1; m_skid_d = alu_dest; m_skid_x = alu_data; end
        end else if (m_skid_v) begin
            got = 1; d = m_skid_d; x = m_skid_x; m_skid_v = 0;
        end else if (fire) begin
            got = 1; d = alu_dest; x = alu_data;
        end
        if (push) m_q.push_back(ld_dest);
        m_we = got && (d != 0);
        if (m_we) begin m_sel = d; m_data = x; end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("rf_we",     32'(rf_we),     32'(m_we));
            check("rf_sel_w",  32'(rf_sel_w),  32'(m_sel));
            check("rf_data",   32'(rf_data),   32'(m_data));
            check("busy",      32'(busy),      32'(m_busy()));
            check("lq_count",  32'(lq_count),  32'(m_q.size()));
            check("err_unexp", 32'(err_unexp), 32'(m_err));
            check("alu_ready", 32'(alu_ready), 32'(!m_skid_v));
            check("ld_ready",  32'(ld_ready),  32'(m_q.size() != LQ_DEPTH));
        end
    end

    task automatic cyc(input bit av, input logic [2:0] ad, input logic [15:0] ax,
                       input bit li, input logic [2:0] ldst, input bit mv, input logic [15:0] mx);
        alu_valid = av; alu_dest = ad; alu_data = ax;
        ld_issue = li; ld_dest = ldst; mem_rvalid = mv; mem_rdata = mx;
        @(posedge clk);
        model_step();
        #1;
        alu_valid = 0; ld_issue = 0; mem_rvalid = 0;
    endtask

    task automatic idle();                 cyc(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input logic [2:0] d, input logic [15:0] x); cyc(1, d, x, 0, 0, 0, 0); endtask
    task automatic ld(input logic [2:0] d); cyc(0, 0, 0, 1, d, 0, 0); endtask
    task automatic rsp(input logic [15:0] x); cyc(0, 0, 0, 0, 0, 1, x); endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rf_we"},     32'(rf_we),     0);
        check({tag, ".rf_sel_w"},  32'(rf_sel_w),  0);
        check({tag, ".rf_data"},   32'(rf_data),   0);
        check({tag, ".busy"},      32'(busy),      0);
        check({tag, ".lq_count"},  32'(lq_count),  0);
        check({tag, ".err_unexp"}, 32'(err_unexp), 0);
        check({tag, ".alu_ready"}, 32'(alu_ready), 1);
        check({tag, ".ld_ready"},  32'(ld_ready),  1);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_vals("rst");
        #6 rst_n = 1'b1;
        chk_en = 1'b1;

        // ALU only
        alu(3, 16'h1234);
        check("alu.we", 32'(rf_we), 1);
        check("alu.sel", 32'(rf_sel_w), 3);
        check("alu.data", 32'(rf_data), 32'h1234);
        check("alu.busy", 32'(busy), 32'h08);
        check("alu.rdy", 32'(alu_ready), 1);
        idle();
        check("alu.we_off", 32'(rf_we), 0);
        check("alu.busy_off", 32'(busy), 0);
        check("alu.hold", 32'(rf_data), 32'h1234);

        // load then response three cycles later
        ld(5);
        check("ld.busy", 32'(busy), 32'h20);
        check("ld.cnt", 32'(lq_count), 1);
        idle(); idle();
        check("ld.busy_wait", 32'(busy), 32'h20);
        rsp(16'hBEEF);
        check("ld.sel", 32'(rf_sel_w), 5);
        check("ld.data", 32'(rf_data), 32'hBEEF);
        check("ld.busy_we", 32'(busy), 32'h20);
        check("ld.cnt0", 32'(lq_count), 0);
        idle();
        check("ld.busy_off", 32'(busy), 0);

        // collision: memory wins, ALU result parked for one cycle
        ld(4);
        cyc(1, 2, 16'h0011, 0, 0, 1, 16'h0022);
        check("col.sel", 32'(rf_sel_w), 4);
        check("col.data", 32'(rf_data), 32'h0022);
        check("col.rdy", 32'(alu_ready), 0);
        check("col.busy", 32'(busy), 32'h14);
        idle();
        check("col.sel2", 32'(rf_sel_w), 2);
        check("col.data2", 32'(rf_data), 32'h0011);
        check("col.rdy2", 32'(alu_ready), 1);
        idle();

        // skid holds while a second response arrives; refused ALU offer is lost
        ld(4); ld(6);
        cyc(1, 2, 16'h0033, 0, 0, 1, 16'h0044);
        cyc(1, 7, 16'h0077, 0, 0, 1, 16'h0066);
        check("hold.sel", 32'(rf_sel_w), 6);
        check("hold.rdy", 32'(alu_ready), 0);
        check("hold.busy", 32'(busy), 32'h44);
        idle();
        check("hold.skid", 32'(rf_data), 32'h0033);
        idle();
        check("hold.drop", 32'(rf_we), 0);

        // queue full, refused issues, in-order drain
        ld(1); ld(2); ld(3); ld(4);
        check("full.rdy", 32'(ld_ready), 0);
        check("full.cnt", 32'(lq_count), 4);
        ld(6);
        check("full.ign", 32'(busy), 32'h1E);
        cyc(0, 0, 0, 1, 6, 1, 16'hAAAA);
        check("full.A", 32'({rf_sel_w, rf_data}), {3'd1, 16'hAAAA});
        check("full.cnt3", 32'(lq_count), 3);
        rsp(16'hBBBB);
        check("full.B", 32'({rf_sel_w, rf_data}), {3'd2, 16'hBBBB});
        rsp(16'hCCCC);
        check("full.C", 32'({rf_sel_w, rf_data}), {3'd3, 16'hCCCC});
        rsp(16'hDDDD);
        check("full.D", 32'({rf_sel_w, rf_data}), {3'd4, 16'hDDDD});
        check("full.b6", 32'(busy), 32'h10);
        idle();

        // wrap-around with simultaneous enqueue and pop
        ld(7);
        cyc(0, 0, 0, 1, 6, 1, 16'h7777);
        check("wrap.sel", 32'(rf_sel_w), 7);
        check("wrap.cnt", 32'(lq_count), 1);
        check("wrap.busy", 32'(busy), 32'hC0);
        rsp(16'h6666);
        check("wrap.sel2", 32'(rf_sel_w), 6);
        check("wrap.cnt0", 32'(lq_count), 0);

        // r0 destination and unexpected response
        ld(0);
        check("r0.busy", 32'(busy), 0);
        check("r0.cnt", 32'(lq_count), 1);
        rsp(16'h5555);
        check("r0.we", 32'(rf_we), 0);
        check("r0.cnt0", 32'(lq_count), 0);
        check("r0.hold", 32'(rf_data), 32'h6666);
        rsp(16'h9999);
        check("unexp.err", 32'(err_unexp), 1);
        check("unexp.we", 32'(rf_we), 0);
        idle();
        check("unexp.sticky", 32'(err_unexp), 1);

        // asynchronous reset with loads pending and skid full
        ld(1); ld(2); ld(5);
        cyc(1, 3, 16'hAAAA, 0, 0, 1, 16'h1111);
        check("pre.rdy", 32'(alu_ready), 0);
        check("pre.cnt", 32'(lq_count), 2);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        model_reset();
        #2 rst_n = 1'b1;
        rsp(16'hDEAD);
        check("post.err", 32'(err_unexp), 1);
        check("post.we", 32'(rf_we), 0);
        check("post.cnt", 32'(lq_count), 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
